pe_block_param: RTL and testbench

- Parametrised successor to the fixed 8-channel, 4-deep PE block.
- One ifmap element per beat is broadcast to NUM_CH multiply-accumulate lanes, each with its own weight.
- Each lane is bias-preloaded and accumulates over a runtime-programmable depth of up to MAX_DEPTH beats.
- Adds valid/ready streaming on input and output; sits between the ifmap/weight buffers and the ofmap writeback.

---
 rtl/pe_block_param_pkg.sv | 34 +++
 rtl/pe_block_param_mac_lane.sv | 61 ++++++
 rtl/pe_block_param.sv | 127 ++++++++++++
 tb/tb_pe_block_param.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pe_block_param_pkg.sv
// -----------------------------------------------------------------------------
// pe_pkg -- shared definitions for the parametrised PE block.
//   * pe_state_e : control FSM encoding (IDLE / ACC / DONE)
//   * PE_DATA_W  : default ifmap/weight width
//   * PE_ACC_W   : default bias/accumulator/ofmap width
//   * sext()     : sign-extend the low from_w bits of a value to PE_MAX_W bits
// Optional build macro used elsewhere in this slice: PE_BLOCK_RELU_EN.
// -----------------------------------------------------------------------------
package pe_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } pe_state_e;

  localparam int PE_DATA_W = 8;
  localparam int PE_ACC_W  = 32;

  // Widest value sext() handles; callers truncate the result to their width.
  localparam int PE_MAX_W  = 64;

  // Replicates bit (from_w-1) into every bit at or above from_w.
  function automatic logic [PE_MAX_W-1:0] sext(input logic [PE_MAX_W-1:0] v,
                                               input int unsigned         from_w);
    logic [PE_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < PE_MAX_W; i++) begin
      r[i] = (i < from_w) ? v[i] : v[from_w-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_block_param_mac_lane.sv
// -----------------------------------------------------------------------------
// pe_mac_lane -- one output channel of the PE block.
// Holds the lane accumulator. It is bias-loaded at job start and then adds one
// full-precision signed product per accepted beat. The sum wraps modulo
// 2^ACC_W.
// Build option: with PE_BLOCK_RELU_EN defined, ofmap is max(acc, 0). The clamp
// is applied combinationally at the output and the accumulator is untouched.
// Ports:
//   clk, rst  clock / asynchronous active-low reset
//   load      capture bias into the accumulator
//   bias      lane bias (signed, ACC_W)
//   acc_en    accumulate ifmap*weight this cycle
//   ifmap     broadcast activation (signed, DATA_W)
//   weight    lane weight (signed, DATA_W)
//   ofmap     lane result (ACC_W)
// -----------------------------------------------------------------------------
module pe_mac_lane
  import pe_pkg::*;
#(
  parameter int DATA_W = PE_DATA_W,
  parameter int ACC_W  = PE_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic signed [ACC_W-1:0]  bias,
  input  logic                     acc_en,
  input  logic signed [DATA_W-1:0] ifmap,
  input  logic signed [DATA_W-1:0] weight,
  output logic        [ACC_W-1:0]  ofmap
);

  logic signed [2*DATA_W-1:0] prod;
  logic        [ACC_W-1:0]    prod_ext;
  logic        [ACC_W-1:0]    acc;

  // The product is kept at full 2*DATA_W precision before widening.
  assign prod     = ifmap * weight;
  assign prod_ext = ACC_W'(sext(PE_MAX_W'(prod), 2 * DATA_W));

  // NOTE: the reset is in the sensitivity list so that rst clears acc
  // immediately, without waiting for a clock edge. State is written with
  // non-blocking (<=) assignments so that every register samples its
  // pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= bias;
    end else if (acc_en) begin
      acc <= acc + prod_ext;
    end
  end

`ifdef PE_BLOCK_RELU_EN
  assign ofmap = acc[ACC_W-1] ? '0 : acc;
`else
  assign ofmap = acc;
`endif

endmodule

// File: rtl/pe_block_param.sv
// -----------------------------------------------------------------------------
// pe_block_param -- NUM_CH-lane multiply-accumulate processing element.
// One ifmap element per beat is broadcast to NUM_CH pe_mac_lane instances. Each
// lane has its own weight and bias. A job is accepted in IDLE, accumulates
// depth beats in ACC, and then presents the result in DONE until out_ready.
// Build option: PE_BLOCK_RELU_EN clamps each ofmap lane at zero.
// Ports:
//   clk, rst             clock / asynchronous active-low reset
//   start, cfg_depth     job launch and depth (clamped to MAX_DEPTH)
//   bias                 per-lane bias, lane c at [c*ACC_W +: ACC_W]
//   in_valid, in_ready   input beat handshake
//   ifmap                broadcast activation
//   weight               per-lane weight, lane c at [c*DATA_W +: DATA_W]
//   out_valid, out_ready result handshake
//   ofmap                per-lane result, lane c at [c*ACC_W +: ACC_W]
//   busy                 high while a job is in flight
// -----------------------------------------------------------------------------
module pe_block_param
  import pe_pkg::*;
#(
  parameter  int DATA_W    = PE_DATA_W,
  parameter  int ACC_W     = PE_ACC_W,
  parameter  int NUM_CH    = 8,
  parameter  int MAX_DEPTH = 16,
  localparam int DEP_W     = $clog2(MAX_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DEP_W-1:0]         cfg_depth,
  input  logic [NUM_CH*ACC_W-1:0]  bias,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        ifmap,
  input  logic [NUM_CH*DATA_W-1:0] weight,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*ACC_W-1:0]  ofmap,
  output logic                     busy
);

  pe_state_e        state;
  logic [DEP_W-1:0] cnt;
  logic [DEP_W-1:0] depth_q;
  logic [DEP_W-1:0] depth_clamped;
  logic             load;
  logic             beat;
  logic             last_beat;

  assign depth_clamped = (cfg_depth > DEP_W'(MAX_DEPTH)) ? DEP_W'(MAX_DEPTH) : cfg_depth;

  // start only counts in IDLE. A start in the DONE handshake cycle is
  // therefore dropped.
  assign load      = (state == S_IDLE) && start;
  assign beat      = in_valid && in_ready;
  assign last_beat = beat && (cnt == depth_q - DEP_W'(1));

  // in_ready, out_valid and busy are registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      depth_q   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            depth_q <= depth_clamped;
            cnt     <= '0;
            busy    <= 1'b1;
            if (depth_clamped != '0) begin
              state    <= S_ACC;
              in_ready <= 1'b1;
            end else begin
              // A zero-depth job presents the bias directly.
              state     <= S_DONE;
              out_valid <= 1'b1;
            end
          end
        end
        S_ACC: begin
          if (beat) begin
            cnt <= cnt + DEP_W'(1);
            if (last_beat) begin
              state     <= S_DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    pe_mac_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .bias   (bias[c*ACC_W +: ACC_W]),
      .acc_en (beat),
      .ifmap  (ifmap),
      .weight (weight[c*DATA_W +: DATA_W]),
      .ofmap  (ofmap[c*ACC_W +: ACC_W])
    );
  end

endmodule

// File: tb/tb_pe_block_param.sv
// -----------------------------------------------------------------------------
// tb_pe_block_param -- directed self-checking bench for pe_block_param with
// default parameters (DATA_W=8, ACC_W=32, NUM_CH=8, MAX_DEPTH=16).
// Expected values are hand-computed. Lane results are passed through post()
// so that one bench serves builds with and without PE_BLOCK_RELU_EN.
// -----------------------------------------------------------------------------
module tb_pe_block_param;

  localparam int DATA_W    = 8;
  localparam int ACC_W     = 32;
  localparam int NUM_CH    = 8;
  localparam int MAX_DEPTH = 16;
  localparam int DEP_W     = 5;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     start = 1'b0;
  logic [DEP_W-1:0]         cfg_depth = '0;
  logic [NUM_CH*ACC_W-1:0]  bias = '0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [DATA_W-1:0]        ifmap = '0;
  logic [NUM_CH*DATA_W-1:0] weight = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic [NUM_CH*ACC_W-1:0]  ofmap;
  logic                     busy;

  int vectors = 0;
  int miscompares = 0;

  pe_block_param #(
    .DATA_W    (DATA_W),
    .ACC_W     (ACC_W),
    .NUM_CH    (NUM_CH),
    .MAX_DEPTH (MAX_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_depth (cfg_depth),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ifmap     (ifmap),
    .weight    (weight),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ofmap     (ofmap),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] post(input logic [31:0] v);
`ifdef PE_BLOCK_RELU_EN
    return v[31] ? 32'd0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [31:0] lane(input int c);
    return ofmap[c*ACC_W +: ACC_W];
  endfunction

  function automatic logic [NUM_CH*ACC_W-1:0] bias_all(input logic [31:0] v);
    logic [NUM_CH*ACC_W-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c*ACC_W +: ACC_W] = v;
    return r;
  endfunction

  function automatic logic [NUM_CH*DATA_W-1:0] weight_all(input logic [7:0] w);
    logic [NUM_CH*DATA_W-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c*DATA_W +: DATA_W] = w;
    return r;
  endfunction

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [DEP_W-1:0] d, input logic [NUM_CH*ACC_W-1:0] b);
    start = 1'b1; cfg_depth = d; bias = b;
    tick();
    start = 1'b0;
  endtask

  task automatic do_beat(input logic [7:0] x, input logic [NUM_CH*DATA_W-1:0] w);
    in_valid = 1'b1; ifmap = x; weight = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [NUM_CH*DATA_W-1:0] wv;
    logic [NUM_CH*ACC_W-1:0]  bv;
    int accepted;

    // ---- reset state ----
    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ofmap0", lane(0), 32'd0);
    rst = 1'b1;
    tick();

    // ---- basic job: depth 4, ifmap 1..4, weight c+1, bias 0x10 ----
    for (int c = 0; c < NUM_CH; c++) wv[c*DATA_W +: DATA_W] = 8'(c + 1);
    do_start(5'd4, bias_all(32'h10));
    check("basic_busy", 32'(busy), 32'd1);
    check("basic_in_ready", 32'(in_ready), 32'd1);
    do_beat(8'd1, wv);
    do_beat(8'd2, wv);
    do_beat(8'd3, wv);
    check("basic_ov_after3", 32'(out_valid), 32'd0);
    do_beat(8'd4, wv);
    check("basic_ov_after4", 32'(out_valid), 32'd1);
    check("basic_ir_done", 32'(in_ready), 32'd0);
    for (int c = 0; c < NUM_CH; c++) check($sformatf("basic_lane%0d", c), lane(c), post(32'(16 + 10 * (c + 1))));
    release_out();
    check("basic_ov_clr", 32'(out_valid), 32'd0);
    check("basic_idle", 32'(busy), 32'd0);

    // ---- signed extremes with a stall ----
    do_start(5'd2, bias_all(32'd0));
    do_beat(8'h80, weight_all(8'h80));
    in_valid = 1'b0; ifmap = 8'h7f; weight = weight_all(8'h7f);
    tick();
    check("stall_in_ready", 32'(in_ready), 32'd1);
    check("stall_ov", 32'(out_valid), 32'd0);
    check("stall_partial", lane(0), post(32'd16384));
    do_beat(8'h80, weight_all(8'h80));
    check("signed_ov", 32'(out_valid), 32'd1);
    check("signed_lane0", lane(0), post(32'h00008000));
    check("signed_lane7", lane(7), post(32'h00008000));

    // ---- backpressure with ignored start pulses ----
    for (int i = 0; i < 5; i++) begin
      start = i[0]; cfg_depth = 5'd3; bias = bias_all(32'h55);
      tick();
      check($sformatf("bp_ov%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("bp_lane%0d", i), lane(3), post(32'h00008000));
    end
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    check("bp_ov_clr", 32'(out_valid), 32'd0);
    check("bp_idle", 32'(busy), 32'd0);
    tick();
    check("bp_start_ignored", 32'(busy), 32'd0);
    check("bp_acc_kept", lane(0), post(32'h00008000));

    // ---- depth 0: bias straight through ----
    for (int c = 0; c < NUM_CH; c++) bv[c*ACC_W +: ACC_W] = 32'(100 + c);
    do_start(5'd0, bv);
    check("d0_ov", 32'(out_valid), 32'd1);
    check("d0_ir", 32'(in_ready), 32'd0);
    check("d0_lane0", lane(0), post(32'd100));
    check("d0_lane7", lane(7), post(32'd107));
    release_out();

    // ---- depth MAX_DEPTH+3 is clamped to MAX_DEPTH beats ----
    do_start(5'(MAX_DEPTH + 3), bias_all(32'd0));
    accepted = 0;
    in_valid = 1'b1; ifmap = 8'd1; weight = weight_all(8'd1);
    for (int i = 0; i < 40 && !out_valid; i++) begin
      if (in_ready) accepted++;
      tick();
    end
    in_valid = 1'b0;
    check("clamp_ov", 32'(out_valid), 32'd1);
    check("clamp_beats", 32'(accepted), 32'(MAX_DEPTH));
    check("clamp_lane0", lane(0), post(32'(MAX_DEPTH)));
    release_out();

    // ---- wrap: 0x7FFFFFFF + 1 ----
    do_start(5'd1, bias_all(32'h7fffffff));
    do_beat(8'd1, weight_all(8'd1));
    check("wrap_ov", 32'(out_valid), 32'd1);
    check("wrap_lane0", lane(0), post(32'h80000000));
    release_out();

    // ---- reset mid-job, then a fresh job ----
    do_start(5'd4, bias_all(32'd5));
    do_beat(8'd1, weight_all(8'd1));
    do_beat(8'd1, weight_all(8'd1));
    #2 rst = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ir", 32'(in_ready), 32'd0);
    check("mid_rst_ov", 32'(out_valid), 32'd0);
    check("mid_rst_ofmap", lane(2), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    for (int c = 0; c < NUM_CH; c++) wv[c*DATA_W +: DATA_W] = 8'(c - 4);
    do_start(5'd2, bias_all(32'h10));
    do_beat(8'd3, wv);
    do_beat(8'd5, wv);
    check("post_rst_ov", 32'(out_valid), 32'd1);
    for (int c = 0; c < NUM_CH; c += 3) check($sformatf("post_rst_lane%0d", c), lane(c), post(32'(8 * c - 16)));
    release_out();

    // ---- negative sum (ReLU dependent) ----
    do_start(5'd2, bias_all(-32'sd100));
    do_beat(8'd4, weight_all(8'd5));
    do_beat(8'd4, weight_all(8'd5));
`ifdef PE_BLOCK_RELU_EN
    check("relu_lane0", lane(0), 32'd0);
`else
    check("relu_lane0", lane(0), 32'hffffffc4);
`endif
    release_out();
    check("final_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
